// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the OV5640 power/reset sequencer:
//   - default cycle constants derived from the 24 MHz camera clock
//   - sequencer state encoding (3 bits, exposed on state_dbg)
//   - packed bundle of the registered sensor-control outputs and the
//     per-state output decode used to load those registers
// ---------------------------------------------------------------------------
package cam_pkg;

  localparam int unsigned CAM_CLK_HZ = 32'd24_000_000;

  // 5 ms, 1 ms, 20 ms and 200 ms at CAM_CLK_HZ
  localparam int unsigned PWR_CYC_DEF    = CAM_CLK_HZ / 32'd200;
  localparam int unsigned RST_CYC_DEF    = CAM_CLK_HZ / 32'd1000;
  localparam int unsigned SCCB_CYC_DEF   = CAM_CLK_HZ / 32'd50;
  localparam int unsigned CFG_TO_CYC_DEF = CAM_CLK_HZ / 32'd5;

  localparam int unsigned MAX_RETRY_DEF  = 32'd3;
  localparam int unsigned CNT_W_DEF      = 32'd23;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PWR   = 3'd1,
    ST_PWDN  = 3'd2,
    ST_RST   = 3'd3,
    ST_REQ   = 3'd4,
    ST_CFG   = 3'd5,
    ST_RUN   = 3'd6,
    ST_FAULT = 3'd7
  } cam_state_t;

  typedef struct packed {
    logic xclk_en;
    logic pwdn;
    logic rst_n;
    logic cfg_start;
    logic ready;
    logic fault;
  } cam_out_t;

  // Values held by the output registers in reset and in IDLE
  localparam cam_out_t CAM_OUT_RESET = '{
    xclk_en:   1'b0,
    pwdn:      1'b1,
    rst_n:     1'b0,
    cfg_start: 1'b0,
    ready:     1'b0,
    fault:     1'b0
  };

  // Output values that belong to a state. The sequencer loads its output
  // registers with the decode of the *next* state, so every output changes
  // on the same edge as the state it belongs to, straight from a flop.
  function automatic cam_out_t out_for_state(input cam_state_t s);
    cam_out_t o;
    o = CAM_OUT_RESET;
    case (s)
      ST_IDLE: begin
        o = CAM_OUT_RESET;
      end
      ST_PWR: begin
        o.xclk_en = 1'b1;
      end
      ST_PWDN: begin
        o.xclk_en = 1'b1;
        o.pwdn    = 1'b0;
      end
      ST_RST: begin
        o.xclk_en = 1'b1;
        o.pwdn    = 1'b0;
        o.rst_n   = 1'b1;
      end
      ST_REQ: begin
        o.xclk_en   = 1'b1;
        o.pwdn      = 1'b0;
        o.rst_n     = 1'b1;
        o.cfg_start = 1'b1;
      end
      ST_CFG: begin
        o.xclk_en = 1'b1;
        o.pwdn    = 1'b0;
        o.rst_n   = 1'b1;
      end
      ST_RUN: begin
        o.xclk_en = 1'b1;
        o.pwdn    = 1'b0;
        o.rst_n   = 1'b1;
        o.ready   = 1'b1;
      end
      ST_FAULT: begin
        o.fault = 1'b1;
      end
      default: begin
        o = CAM_OUT_RESET;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/delay_counter.sv
// ---------------------------------------------------------------------------
// delay_counter
// Shared interval counter for all timed sequencer states.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (count -> 0)
//   clr    in   clear count to 0 (priority over en)
//   en     in   increment count by one
//   target in   CNT_W interval length in cycles for the current state
//   hit    out  count == target-1, i.e. the last cycle of the interval
// The owner clears the count on every state change, so the count never
// reaches target and never wraps for legal CNT_W.
// ---------------------------------------------------------------------------
module delay_counter #(
  parameter int unsigned CNT_W = 32'd23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] target,
  output logic             hit
);

  logic [CNT_W-1:0] count_r;

  // Count register: reset/clear to zero, otherwise advance when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // Terminal-count decode
  always_comb begin
    hit = (count_r == (target - {{(CNT_W-1){1'b0}}, 1'b1}));
  end

endmodule

// File: rtl/ov5640_power_seq.sv
// ---------------------------------------------------------------------------
// ov5640_power_seq
// Power-up / reset sequencer for the OV5640 sensor in the 24 MHz camera
// clock domain. After PLL lock it enables XCLK, releases PWDN and then
// RESETB with datasheet delays, requests SCCB configuration, and supervises
// it with a timeout and a bounded number of full re-sequence retries.
// Ports:
//   clk        in   camera clock (PLL clkout0)
//   rst        in   synchronous active-high reset
//   pll_lock   in   camera PLL lock, already synchronous to clk
//   cfg_done   in   SCCB configuration finished OK (level or pulse)
//   cfg_err    in   SCCB configuration NACK/error pulse
//   xclk_en    out  XCLK output buffer enable
//   cam_pwdn   out  sensor power-down, active-high
//   cam_rst_n  out  sensor RESETB, active-low
//   cfg_start  out  one-cycle configuration start pulse
//   cam_ready  out  sensor configured, capture may run
//   fault      out  sticky: every configuration attempt failed
//   state_dbg  out  current state encoding
// All outputs are registers.
// ---------------------------------------------------------------------------
module ov5640_power_seq
  import cam_pkg::*;
#(
  parameter int unsigned PWR_CYC    = PWR_CYC_DEF,
  parameter int unsigned RST_CYC    = RST_CYC_DEF,
  parameter int unsigned SCCB_CYC   = SCCB_CYC_DEF,
  parameter int unsigned CFG_TO_CYC = CFG_TO_CYC_DEF,
  parameter int unsigned MAX_RETRY  = MAX_RETRY_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       cfg_done,
  input  logic       cfg_err,
  output logic       xclk_en,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       cfg_start,
  output logic       cam_ready,
  output logic       fault,
  output logic [2:0] state_dbg
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 32'd1);
  // Retry count at which one more failure is final
  localparam logic [RETRY_W-1:0] LAST_TRY = RETRY_W'(MAX_RETRY - 32'd1);

  cam_state_t       state_r;
  cam_state_t       state_next_s;
  logic [RETRY_W-1:0] retry_r;
  logic [RETRY_W-1:0] retry_next_s;
  cam_out_t         out_r;

  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic [CNT_W-1:0] cnt_target_s;
  logic             cnt_hit_s;
  logic             cfg_fail_s;

  // Interval selection for the shared counter and its enable/clear
  always_comb begin
    cnt_target_s = CNT_W'(PWR_CYC);
    cnt_en_s     = 1'b0;
    case (state_r)
      ST_PWR: begin
        cnt_target_s = CNT_W'(PWR_CYC);
        cnt_en_s     = 1'b1;
      end
      ST_PWDN: begin
        cnt_target_s = CNT_W'(RST_CYC);
        cnt_en_s     = 1'b1;
      end
      ST_RST: begin
        cnt_target_s = CNT_W'(SCCB_CYC);
        cnt_en_s     = 1'b1;
      end
      ST_CFG: begin
        cnt_target_s = CNT_W'(CFG_TO_CYC);
        cnt_en_s     = 1'b1;
      end
      default: begin
        cnt_target_s = CNT_W'(PWR_CYC);
        cnt_en_s     = 1'b0;
      end
    endcase
    // Every state change (including CFG -> PWR re-sequence) restarts timing
    cnt_clr_s = (state_next_s != state_r);
  end

  delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .target (cnt_target_s),
    .hit    (cnt_hit_s)
  );

  // Next-state and retry bookkeeping
  always_comb begin
    state_next_s = state_r;
    retry_next_s = retry_r;
    // Error or timeout is a failure even if cfg_done arrives in the same cycle
    cfg_fail_s   = cfg_err || cnt_hit_s;

    case (state_r)
      ST_IDLE: begin
        if (pll_lock) begin
          state_next_s = ST_PWR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PWR: begin
        if (cnt_hit_s) begin
          state_next_s = ST_PWDN;
        end else begin
          state_next_s = ST_PWR;
        end
      end
      ST_PWDN: begin
        if (cnt_hit_s) begin
          state_next_s = ST_RST;
        end else begin
          state_next_s = ST_PWDN;
        end
      end
      ST_RST: begin
        if (cnt_hit_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_RST;
        end
      end
      ST_REQ: begin
        state_next_s = ST_CFG;
      end
      ST_CFG: begin
        if (cfg_fail_s) begin
          retry_next_s = retry_r + {{(RETRY_W-1){1'b0}}, 1'b1};
          if (retry_r == LAST_TRY) begin
            state_next_s = ST_FAULT;
          end else begin
            // Full power cycle of the sensor: PWR drives pwdn=1, rst_n=0
            state_next_s = ST_PWR;
          end
        end else if (cfg_done) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_CFG;
        end
      end
      ST_RUN: begin
        state_next_s = ST_RUN;
      end
      ST_FAULT: begin
        state_next_s = ST_FAULT;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    // Lock loss overrides everything except the sticky fault
    if (!pll_lock && (state_r != ST_FAULT)) begin
      state_next_s = ST_IDLE;
      retry_next_s = '0;
    end else begin
      state_next_s = state_next_s;
      retry_next_s = retry_next_s;
    end
  end

  // State, retry and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      retry_r <= '0;
      out_r   <= CAM_OUT_RESET;
    end else begin
      state_r <= state_next_s;
      retry_r <= retry_next_s;
      out_r   <= out_for_state(state_next_s);
    end
  end

  assign xclk_en   = out_r.xclk_en;
  assign cam_pwdn  = out_r.pwdn;
  assign cam_rst_n = out_r.rst_n;
  assign cfg_start = out_r.cfg_start;
  assign cam_ready = out_r.ready;
  assign fault     = out_r.fault;
  assign state_dbg = state_r;

endmodule

// File: tb/tb_ov5640_power_seq.sv
// ---------------------------------------------------------------------------
// tb_ov5640_power_seq
// Directed bench for ov5640_power_seq with shortened timing
// (PWR=10, RST=4, SCCB=6, CFG_TO=20, MAX_RETRY=3). "cycle N" is the value
// seen just after the N-th rising edge following the cycle in which
// pll_lock is raised (cycle 0).
// ---------------------------------------------------------------------------
module tb_ov5640_power_seq;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       cfg_done;
  logic       cfg_err;
  logic       xclk_en;
  logic       cam_pwdn;
  logic       cam_rst_n;
  logic       cfg_start;
  logic       cam_ready;
  logic       fault;
  logic [2:0] state_dbg;

  int checks;
  int errors;
  int cyc;
  int n_start;
  int start_base;

  ov5640_power_seq #(
    .PWR_CYC    (10),
    .RST_CYC    (4),
    .SCCB_CYC   (6),
    .CFG_TO_CYC (20),
    .MAX_RETRY  (3),
    .CNT_W      (23)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .xclk_en   (xclk_en),
    .cam_pwdn  (cam_pwdn),
    .cam_rst_n (cam_rst_n),
    .cfg_start (cfg_start),
    .cam_ready (cam_ready),
    .fault     (fault),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cfg_start pulse counter, sampled mid-cycle
  initial n_start = 0;
  always @(negedge clk) begin
    if (cfg_start === 1'b1) n_start = n_start + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  // Reset values double as IDLE values except for the state code
  task automatic check_idle(input string tag, input logic [2:0] st);
    check({tag, ".state"}, {29'd0, state_dbg}, {29'd0, st});
    check({tag, ".xclk"},  {31'd0, xclk_en},   32'd0);
    check({tag, ".pwdn"},  {31'd0, cam_pwdn},  32'd1);
    check({tag, ".rstn"},  {31'd0, cam_rst_n}, 32'd0);
    check({tag, ".start"}, {31'd0, cfg_start}, 32'd0);
    check({tag, ".ready"}, {31'd0, cam_ready}, 32'd0);
    check({tag, ".fault"}, {31'd0, fault},     32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rst      = 1'b1;
    pll_lock = 1'b0;
    cfg_done = 1'b0;
    cfg_err  = 1'b0;

    // ---------------- reset ----------------
    tick(); tick(); tick();
    check_idle("reset", 3'd0);

    // ---------------- nominal ----------------
    rst = 1'b0; pll_lock = 1'b1; cyc = 0;
    tick();
    check("nom.xclk1",   {31'd0, xclk_en},  32'd1);
    check("nom.state1",  {29'd0, state_dbg}, 32'd1);
    check("nom.pwdn1",   {31'd0, cam_pwdn}, 32'd1);
    goto(10);
    check("nom.pwdn10",  {31'd0, cam_pwdn}, 32'd1);
    goto(11);
    check("nom.pwdn11",  {31'd0, cam_pwdn}, 32'd0);
    check("nom.state11", {29'd0, state_dbg}, 32'd2);
    goto(14);
    check("nom.rstn14",  {31'd0, cam_rst_n}, 32'd0);
    goto(15);
    check("nom.rstn15",  {31'd0, cam_rst_n}, 32'd1);
    goto(20);
    check("nom.start20", {31'd0, cfg_start}, 32'd0);
    goto(21);
    check("nom.start21", {31'd0, cfg_start}, 32'd1);
    check("nom.state21", {29'd0, state_dbg}, 32'd4);
    goto(22);
    check("nom.start22", {31'd0, cfg_start}, 32'd0);
    check("nom.state22", {29'd0, state_dbg}, 32'd5);
    goto(26);
    check("nom.ready26", {31'd0, cam_ready}, 32'd0);
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
    check("nom.ready27", {31'd0, cam_ready}, 32'd1);
    check("nom.state27", {29'd0, state_dbg}, 32'd6);
    // RUN ignores cfg_err
    cfg_err = 1'b1;
    tick();
    cfg_err = 1'b0;
    check("run.ignore_err", {29'd0, state_dbg}, 32'd6);
    check("run.ready",      {31'd0, cam_ready}, 32'd1);

    // ---------------- lock loss in RUN ----------------
    pll_lock = 1'b0;
    tick();
    check_idle("lossrun", 3'd0);
    pll_lock = 1'b1; cyc = 0;
    tick();
    check("relock.state1", {29'd0, state_dbg}, 32'd1);
    goto(10);
    check("relock.pwdn10", {31'd0, cam_pwdn}, 32'd1);
    goto(11);
    check("relock.pwdn11", {31'd0, cam_pwdn}, 32'd0);
    goto(12);
    check("relock.pwdnst", {29'd0, state_dbg}, 32'd2);

    // ---------------- lock loss in PWDN ----------------
    pll_lock = 1'b0;
    tick();
    check_idle("losspwdn", 3'd0);

    // ---------------- timeout retry then success ----------------
    pll_lock = 1'b1; cyc = 0;
    goto(21);
    check("to.start21", {31'd0, cfg_start}, 32'd1);
    goto(41);
    check("to.state41", {29'd0, state_dbg}, 32'd5);
    check("to.pwdn41",  {31'd0, cam_pwdn},  32'd0);
    goto(42);
    check("to.state42", {29'd0, state_dbg}, 32'd1);
    check("to.pwdn42",  {31'd0, cam_pwdn},  32'd1);
    check("to.rstn42",  {31'd0, cam_rst_n}, 32'd0);
    check("to.xclk42",  {31'd0, xclk_en},   32'd1);
    goto(52);
    check("to.pwdn52",  {31'd0, cam_pwdn},  32'd0);
    goto(61);
    check("to.start61", {31'd0, cfg_start}, 32'd0);
    goto(62);
    check("to.start62", {31'd0, cfg_start}, 32'd1);
    goto(63);
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
    check("to.ready64", {31'd0, cam_ready}, 32'd1);
    check("to.fault64", {31'd0, fault},     32'd0);
    check("to.state64", {29'd0, state_dbg}, 32'd6);

    // ---------------- fault (first attempt: done+err together) ----------------
    rst = 1'b1;
    tick();
    check_idle("rstrun", 3'd0);
    rst = 1'b0; cyc = 0; start_base = n_start;
    goto(22);
    cfg_done = 1'b1; cfg_err = 1'b1;
    tick();
    cfg_done = 1'b0; cfg_err = 1'b0;
    check("both.state23", {29'd0, state_dbg}, 32'd1);
    check("both.ready23", {31'd0, cam_ready}, 32'd0);
    check("both.pwdn23",  {31'd0, cam_pwdn},  32'd1);
    goto(43);
    check("flt.start43", {31'd0, cfg_start}, 32'd1);
    goto(44);
    cfg_err = 1'b1;
    tick();
    cfg_err = 1'b0;
    check("flt.state45", {29'd0, state_dbg}, 32'd1);
    goto(65);
    check("flt.start65", {31'd0, cfg_start}, 32'd1);
    goto(66);
    cfg_err = 1'b1;
    tick();
    cfg_err = 1'b0;
    check("flt.state",  {29'd0, state_dbg}, 32'd7);
    check("flt.fault",  {31'd0, fault},     32'd1);
    check("flt.xclk",   {31'd0, xclk_en},   32'd0);
    check("flt.pwdn",   {31'd0, cam_pwdn},  32'd1);
    check("flt.rstn",   {31'd0, cam_rst_n}, 32'd0);
    check("flt.ready",  {31'd0, cam_ready}, 32'd0);
    check("flt.nstart", n_start - start_base, 32'd3);
    // Fault is sticky, even across lock loss
    pll_lock = 1'b0;
    goto(72);
    check("flt.sticky",       {31'd0, fault},     32'd1);
    check("flt.sticky_state", {29'd0, state_dbg}, 32'd7);

    // ---------------- reset in FAULT ----------------
    rst = 1'b1;
    tick();
    check_idle("rstfault", 3'd0);

    // ---------------- reset in CFG ----------------
    rst = 1'b0; pll_lock = 1'b1; cyc = 0;
    goto(24);
    check("cfg.state24", {29'd0, state_dbg}, 32'd5);
    rst = 1'b1;
    tick();
    check_idle("rstcfg", 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov5640_power_seq.md
Name: ov5640_power_seq

Overview:
- Power-up and reset sequencer for the OV5640 sensor.
- Runs in the 24 MHz camera clock domain produced by the camera PLL (75 MHz × 16 / 50).
- Enables XCLK to the sensor, then drives PWDN and RESETB with datasheet timing.
- Requests SCCB register configuration and supervises it with a timeout and bounded retries. It reports `cam_ready` to the capture and raw2rgb pipeline.

Parameters:
- PWR_CYC, 120000, cycles from lock to PWDN release (5 ms at 24 MHz)
- RST_CYC, 24000, cycles from PWDN release to RESETB release (1 ms)
- SCCB_CYC, 480000, cycles from RESETB release to configuration request (20 ms)
- CFG_TO_CYC, 4800000, configuration timeout (200 ms)
- MAX_RETRY, 3, configuration attempts before fault
- CNT_W, 23, delay counter width; must hold max(all *_CYC)

Ports:
- clk  in  1  camera clock (PLL clkout0)
- rst  in  1  synchronous, active-high reset
- pll_lock  in  1  camera PLL lock, already synchronised to clk
- cfg_done  in  1  SCCB configurator finished OK; level or pulse accepted
- cfg_err  in  1  SCCB configurator NACK/error, 1-cycle pulse
- xclk_en  out  1  enables the XCLK output buffer to the sensor
- cam_pwdn  out  1  sensor power-down, active-high
- cam_rst_n  out  1  sensor RESETB, active-low
- cfg_start  out  1  1-cycle pulse that starts the SCCB configuration
- cam_ready  out  1  sensor configured; downstream capture may run
- fault  out  1  sticky; MAX_RETRY attempts have failed
- state_dbg  out  3  current state encoding

Behaviour:
- Reset values (all registered outputs): xclk_en=0, cam_pwdn=1, cam_rst_n=0, cfg_start=0, cam_ready=0, fault=0, state=IDLE, counter=0, retry=0.
- State encoding: IDLE=0, PWR=1, PWDN=2, RST=3, REQ=4, CFG=5, RUN=6, FAULT=7.
- IDLE:
  - xclk_en=0, pwdn=1, rst_n=0.
  - When pll_lock=1, go to PWR and clear the counter.
- PWR:
  - xclk_en=1; counter increments.
  - When counter==PWR_CYC-1, go to PWDN, set cam_pwdn=0 and clear the counter.
- PWDN:
  - When counter==RST_CYC-1, go to RST, set cam_rst_n=1 and clear the counter.
- RST:
  - When counter==SCCB_CYC-1, go to REQ.
- REQ:
  - Asserts cfg_start for exactly one cycle.
  - Next state is CFG; counter cleared.
- CFG (counter increments):
  - cfg_done=1 → RUN; cam_ready=1 from the next cycle.
  - cfg_err=1, or counter==CFG_TO_CYC-1, counts as a failure; retry increments.
  - On failure with retry+1 < MAX_RETRY: go to IDLE-equivalent re-sequence, i.e. pwdn=1, rst_n=0, enter PWR with the counter cleared, then full timing again.
  - On failure with retry+1 == MAX_RETRY: go to FAULT.
  - cfg_done and cfg_err in the same cycle: cfg_err wins.
- RUN:
  - Holds all outputs.
  - cfg_done/cfg_err are ignored.
- FAULT:
  - fault=1, cam_pwdn=1, cam_rst_n=0, xclk_en=0, cam_ready=0.
  - Exits only via rst.
- pll_lock loss (pll_lock=0) in any state except FAULT:
  - Next cycle state=IDLE; outputs take their IDLE values; counter and retry are cleared; cam_ready drops with no delay beyond that one cycle.
- Latency: first cfg_start occurs exactly PWR_CYC+RST_CYC+SCCB_CYC+1 cycles after the first clk edge on which pll_lock=1 is sampled in IDLE.
- Counter never wraps. It is compared for equality and cleared on every transition; CNT_W overflow is a parameter error.
- rst asserted mid-sequence: all outputs return to reset values on the next edge; fault is cleared.
- All outputs come straight from flops; no combinational paths from inputs to outputs.

Decomposition:
- Shared package `cam_pkg`:
  - state enum/localparams (IDLE..FAULT, 3-bit)
  - default cycle constants derived from CAM_CLK_HZ=24_000_000
- Single sub-module `delay_counter`:
  - inputs clr, en
  - output `hit` when count==target-1
  - parameterised by CNT_W
  - instantiated once and shared by all timed states through a target mux.

Test Plan (parameters overridden to PWR_CYC=10, RST_CYC=4, SCCB_CYC=6, CFG_TO_CYC=20, MAX_RETRY=3):
- Nominal:
  - Stimulus: rst released, pll_lock=1 at cycle 0; cfg_done pulsed 5 cycles after cfg_start.
  - Required: xclk_en=1 at cycle 1; pwdn 1→0 at cycle 11; rst_n 0→1 at 15; cfg_start single pulse at 21; cam_ready=1 at 27.
- Timeout retry then success:
  - Stimulus: no cfg_done on the first attempt; cfg_done on the second.
  - Required: pwdn returns to 1 and rst_n to 0 the cycle after timeout; full re-sequence runs; second cfg_start 21 cycles later; cam_ready=1; fault=0.
- Fault:
  - Stimulus: cfg_err pulsed on every attempt.
  - Required: exactly 3 cfg_start pulses; then fault=1, state_dbg=7, xclk_en=0; fault persists until rst.
- Lock loss:
  - Stimulus: drop pll_lock in PWDN, and separately in RUN.
  - Required: next cycle state_dbg=0, cam_pwdn=1, cam_rst_n=0, cam_ready=0; when lock returns, the sequence restarts with full timing.
- Simultaneous cfg_done and cfg_err in CFG.
  - Required: treated as failure; retry increments; no cam_ready.
- Reset mid-operation:
  - Stimulus: rst asserted in CFG and in FAULT.
  - Required: all outputs at reset values on the next edge; fault cleared.
